serv_mem_bridge: RTL and testbench
==================================

Name: serv_mem_bridge

Overview:
- Wishbone data-bus master between the bit-serial core and data memory.
- Upstream: state/decode logic issues a load/store request. Downstream: the 32-bit data buffer register, which supplies store data and receives load data.
- Issues one bus cycle per request and computes byte selects from size and address LSBs.
- Rejects misaligned accesses, aborts hung cycles via a timeout, and returns load data as a one-cycle load strobe.
- Also generates the per-byte valid qualifier used while the buffer register shifts store data into position.

Parameters:
- TIMEOUT, 255: bus cycles to wait for i_wb_ack before abort. 0 disables the timeout. Legal range 0..65535.
- TW, $clog2(TIMEOUT+1) (minimum 1): width of the timeout counter. Derived; do not override.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  request strobe; sampled only in IDLE.
- i_we  in  1  1 = store, 0 = load. Sampled with i_req.
- i_size  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- i_adr  in  32  byte address. Sampled with i_req.
- i_dat  in  32  store data, already lane-aligned by the buffer register. Sampled with i_req.
- i_bytecnt  in  2  current byte index from the serial counter.
- o_byte_valid  out  1  combinational byte qualifier for the buffer register.
- o_busy  out  1  high whenever state != IDLE.
- o_ack  out  1  one-cycle pulse: access completed successfully.
- o_err  out  1  one-cycle pulse: misaligned access or timeout.
- o_load  out  1  one-cycle pulse: o_rdat holds valid load data.
- o_rdat  out  32  registered read data.
- o_wb_cyc  out  1  Wishbone cycle.
- o_wb_stb  out  1  Wishbone strobe; always equal to o_wb_cyc.
- o_wb_we  out  1  Wishbone write enable.
- o_wb_adr  out  30  word address, i_adr[31:2].
- o_wb_sel  out  4  byte-lane selects.
- o_wb_dat  out  32  Wishbone write data.
- i_wb_ack  in  1  Wishbone acknowledge.
- i_wb_rdt  in  32  Wishbone read data.

Behaviour:
- Reset:
  - i_rst_n low forces state IDLE immediately and asynchronously, including mid-cycle; o_wb_cyc drops without waiting for a clock edge.
  - Reset values: o_wb_cyc/stb/we = 0, o_wb_adr/sel/dat = 0, o_rdat = 0, o_ack/o_err/o_load = 0, timeout counter = 0.
- States: IDLE, BUSY, RESP, FAIL. All control outputs are registered.
- Misalignment check: misaligned when (size == half & adr[0]) or (size >= word & adr[1:0] != 0).
- Byte selects:
  - byte: 4'b0001 << adr[1:0]
  - half: adr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- IDLE:
  - i_req & !misaligned → BUSY. On the same edge latch we, adr[31:2], sel and dat into the bus registers, set cyc = stb = 1, clear the counter.
  - i_req & misaligned → FAIL. No bus cycle is issued.
- BUSY:
  - i_wb_ack & we → IDLE. cyc = 0 and o_ack = 1 on the same edge.
  - i_wb_ack & !we → RESP. cyc = 0 and o_rdat = i_wb_rdt on the same edge.
  - No ack and counter == TIMEOUT-1 (TIMEOUT != 0) → FAIL. cyc = 0.
  - Otherwise the counter increments.
- Ack and timeout expiry in the same cycle: ack wins.
- RESP: o_load = 1 and o_ack = 1 for exactly this one cycle, then → IDLE.
- FAIL: o_err = 1 for exactly this one cycle, then → IDLE.
- Latency:
  - Store: o_ack one cycle after the ack edge.
  - Load: o_load/o_ack two cycles after the ack edge.
  - Minimum request-to-request spacing: 3 cycles for stores, 4 for loads.
- Ignored inputs:
  - i_req outside IDLE is ignored; no queuing.
  - i_wb_ack outside BUSY is ignored.
- o_rdat holds its value until the next load ack.
- o_byte_valid = (i_size >= word) | (i_bytecnt == 0) | (i_size == half & !i_bytecnt[1]).
  - Purely combinational.
  - Independent of state, so the buffer register can pre-position store data before i_req.

Test Plan:
- Word store: adr=0x1000, dat=0xDEADBEEF, we=1, ack after 3 cycles → cyc high for 4 cycles; sel=1111, adr=0x400, wb_dat=0xDEADBEEF; o_ack one cycle after the ack edge; o_err=0.
- Byte load: adr=0x2003, size=00, wb_rdt=0x11223344 → sel=1000; o_rdat=0x11223344; o_load and o_ack both pulse for 1 cycle, 2 cycles after ack.
- Misaligned: half at adr=0x3001, and separately word at adr=0x3002 → cyc never asserts; o_err pulses 1 cycle after i_req; back in IDLE.
- Timeout: TIMEOUT=4, no ack → cyc high exactly 4 cycles, then o_err pulse and IDLE. With TIMEOUT=0, cyc stays high for 1000 cycles with no error.
- Races: ack arriving in the timeout-expiry cycle → o_ack, no o_err. Reset asserted mid-BUSY → cyc low before the next edge, and a later ack is ignored.
- o_byte_valid sweep: bytecnt 0..3 × size byte/half/word → 1000, 1100, 1111 respectively (bytecnt 0..3 order); toggling i_req while BUSY causes no extra bus cycle.

Source files
------------

// File: rtl/serv_mem_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : serv_mem_bridge_if
//  Purpose  : Request/response and Wishbone signal bundle for serv_mem_bridge.
//  Revision : 1.0 - initial release
// ============================================================================
interface serv_mem_bridge_if;
    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic [31:0] i_adr;
    logic [31:0] i_dat;
    logic [1:0]  i_bytecnt;
    logic        o_byte_valid;
    logic        o_busy;
    logic        o_ack;
    logic        o_err;
    logic        o_load;
    logic [31:0] o_rdat;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [29:0] o_wb_adr;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_dat;
    logic        i_wb_ack;
    logic [31:0] i_wb_rdt;

    // The bridge is the Wishbone master; the core/memory side is the slave view.
    modport master (
        input  i_req, i_we, i_size, i_adr, i_dat, i_bytecnt, i_wb_ack, i_wb_rdt,
        output o_byte_valid, o_busy, o_ack, o_err, o_load, o_rdat,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat
    );

    modport slave (
        output i_req, i_we, i_size, i_adr, i_dat, i_bytecnt, i_wb_ack, i_wb_rdt,
        input  o_byte_valid, o_busy, o_ack, o_err, o_load, o_rdat,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat
    );
endinterface
`default_nettype wire

// File: rtl/serv_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : serv_mem_bridge
//  Purpose  : Wishbone data-bus master for the bit-serial core's load/store path.
//  Revision : 1.0 - initial release
// ============================================================================
module serv_mem_bridge #(
    parameter int TIMEOUT = 255
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst_n,
    serv_mem_bridge_if.master   bus
);

    localparam int TW = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] C_TLAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_BUSY = 2'd1;
    localparam logic [1:0] C_RESP = 2'd2;
    localparam logic [1:0] C_FAIL = 2'd3;

    logic [1:0]    r_state;
    logic [TW-1:0] r_cnt;
    logic          r_cyc;
    logic          r_we;
    logic [29:0]   r_adr;
    logic [3:0]    r_sel;
    logic [31:0]   r_dat;
    logic [31:0]   r_rdat;
    logic          r_ack;
    logic          r_err;
    logic          r_load;

    logic          w_misaligned;
    logic [3:0]    w_sel;

    // Size 2'b11 behaves as a word everywhere.
    assign w_misaligned = ((bus.i_size == 2'b01) & bus.i_adr[0]) |
                          (bus.i_size[1] & (bus.i_adr[1:0] != 2'b00));

    always_comb begin
        w_sel = 4'b1111;
        case (bus.i_size)
            2'b00:   w_sel = 4'b0001 << bus.i_adr[1:0];
            2'b01:   w_sel = bus.i_adr[1] ? 4'b1100 : 4'b0011;
            default: w_sel = 4'b1111;
        endcase
    end

    // State-independent so store data can be positioned before the request.
    assign bus.o_byte_valid = bus.i_size[1] | (bus.i_bytecnt == 2'b00) |
                              ((bus.i_size == 2'b01) & ~bus.i_bytecnt[1]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= C_IDLE;
            r_cnt   <= '0;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_rdat  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_load <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (bus.i_req) begin
                        if (w_misaligned) begin
                            r_state <= C_FAIL;
                        end else begin
                            r_state <= C_BUSY;
                            r_cyc   <= 1'b1;
                            r_we    <= bus.i_we;
                            r_adr   <= bus.i_adr[31:2];
                            r_sel   <= w_sel;
                            r_dat   <= bus.i_dat;
                            r_cnt   <= '0;
                        end
                    end
                end
                C_BUSY: begin
                    // An ack in the expiry cycle still completes the access.
                    if (bus.i_wb_ack) begin
                        r_cyc <= 1'b0;
                        if (r_we) begin
                            r_state <= C_IDLE;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= C_RESP;
                            r_rdat  <= bus.i_wb_rdt;
                        end
                    end else if ((TIMEOUT != 0) && (r_cnt == C_TLAST)) begin
                        r_cyc   <= 1'b0;
                        r_state <= C_FAIL;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                C_RESP: begin
                    r_load  <= 1'b1;
                    r_ack   <= 1'b1;
                    r_state <= C_IDLE;
                end
                default: begin
                    r_err   <= 1'b1;
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy   = (r_state != C_IDLE);
    assign bus.o_ack    = r_ack;
    assign bus.o_err    = r_err;
    assign bus.o_load   = r_load;
    assign bus.o_rdat   = r_rdat;
    assign bus.o_wb_cyc = r_cyc;
    assign bus.o_wb_stb = r_cyc;
    assign bus.o_wb_we  = r_we;
    assign bus.o_wb_adr = r_adr;
    assign bus.o_wb_sel = r_sel;
    assign bus.o_wb_dat = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_serv_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serv_mem_bridge
//  Purpose  : Directed, table-driven bench; drives two bridges (TIMEOUT=0 and 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serv_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, wb_ack;
    logic [1:0]  size, bytecnt;
    logic [31:0] adr, dat, wb_rdt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serv_mem_bridge_if bus0 ();
    serv_mem_bridge_if bus4 ();

    assign bus0.i_req = req;     assign bus4.i_req = req;
    assign bus0.i_we = we;       assign bus4.i_we = we;
    assign bus0.i_size = size;   assign bus4.i_size = size;
    assign bus0.i_adr = adr;     assign bus4.i_adr = adr;
    assign bus0.i_dat = dat;     assign bus4.i_dat = dat;
    assign bus0.i_bytecnt = bytecnt; assign bus4.i_bytecnt = bytecnt;
    assign bus0.i_wb_ack = wb_ack;   assign bus4.i_wb_ack = wb_ack;
    assign bus0.i_wb_rdt = wb_rdt;   assign bus4.i_wb_rdt = wb_rdt;

    serv_mem_bridge #(.TIMEOUT(0)) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0.master));
    serv_mem_bridge #(.TIMEOUT(4)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4.master));

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdt;
        logic [3:0]  sel;
        logic        err;
    } txn_t;

    typedef struct {
        logic [1:0] size;
        logic [1:0] cnt;
        logic       bv;
    } bv_t;

    localparam int NTV = 11;
    txn_t tv  [NTV];
    bv_t  bvt [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_rdat;
        logic [3:0]  pats [4];
        int          hi, err_at, bad_cyc, bad_err, bad_adr;

        tv[0]  = '{1'b0, 2'b00, 32'h0000_2003, 32'h0,         32'h1122_3344, 4'b1000, 1'b0};
        tv[1]  = '{1'b1, 2'b00, 32'h0000_2001, 32'h0000_AB00, 32'h0,         4'b0010, 1'b0};
        tv[2]  = '{1'b1, 2'b01, 32'h0000_2002, 32'h1234_0000, 32'h0,         4'b1100, 1'b0};
        tv[3]  = '{1'b0, 2'b01, 32'h0000_2000, 32'h0,         32'hA5A5_0F0F, 4'b0011, 1'b0};
        tv[4]  = '{1'b0, 2'b01, 32'h0000_3001, 32'h0,         32'h0,         4'b0000, 1'b1};
        tv[5]  = '{1'b1, 2'b10, 32'h0000_3002, 32'h5555_AAAA, 32'h0,         4'b0000, 1'b1};
        tv[6]  = '{1'b0, 2'b11, 32'h0000_4004, 32'h0,         32'hCAFE_F00D, 4'b1111, 1'b0};
        tv[7]  = '{1'b1, 2'b11, 32'h0000_4001, 32'h0,         32'h0,         4'b0000, 1'b1};
        tv[8]  = '{1'b1, 2'b00, 32'h0000_2000, 32'h0000_0077, 32'h0,         4'b0001, 1'b0};
        tv[9]  = '{1'b0, 2'b10, 32'h0000_5008, 32'h0,         32'h89AB_CDEF, 4'b1111, 1'b0};
        tv[10] = '{1'b1, 2'b00, 32'h0000_2002, 32'h0033_0000, 32'h0,         4'b0100, 1'b0};

        // Bit [3-cnt] of each pattern is the expected qualifier for that byte index.
        pats[0] = 4'b1000; pats[1] = 4'b1100; pats[2] = 4'b1111; pats[3] = 4'b1111;
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 4; c++)
                bvt[s*4+c] = '{2'(s), 2'(c), pats[s][3-c]};

        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; bytecnt = 2'b00;
        adr = '0; dat = '0; wb_ack = 1'b0; wb_rdt = '0;
        tick(); tick();
        chk1 ("rst_cyc",  bus0.o_wb_cyc, 1'b0);
        chk1 ("rst_stb",  bus0.o_wb_stb, 1'b0);
        chk1 ("rst_we",   bus0.o_wb_we,  1'b0);
        chk32("rst_adr",  {2'b0, bus0.o_wb_adr}, 32'h0);
        chk32("rst_sel",  {28'b0, bus0.o_wb_sel}, 32'h0);
        chk32("rst_dat",  bus0.o_wb_dat, 32'h0);
        chk32("rst_rdat", bus0.o_rdat, 32'h0);
        chk1 ("rst_ack",  bus0.o_ack,  1'b0);
        chk1 ("rst_err",  bus0.o_err,  1'b0);
        chk1 ("rst_load", bus0.o_load, 1'b0);
        chk1 ("rst_busy", bus0.o_busy, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            size = bvt[i].size; bytecnt = bvt[i].cnt;
            #1;
            chk1($sformatf("byte_valid[s%0d c%0d]", bvt[i].size, bvt[i].cnt), bus0.o_byte_valid, bvt[i].bv);
        end
        tick();

        // Word store, ack in the 4th bus cycle: also the expiry cycle of the TIMEOUT=4 bridge.
        req = 1'b1; we = 1'b1; size = 2'b10; adr = 32'h0000_1000; dat = 32'hDEAD_BEEF;
        tick();
        req = 1'b0;
        chk32("st_sel", {28'b0, bus0.o_wb_sel}, 32'hF);
        chk32("st_adr", {2'b0, bus0.o_wb_adr}, 32'h400);
        chk32("st_dat", bus0.o_wb_dat, 32'hDEAD_BEEF);
        chk1 ("st_we",  bus0.o_wb_we, 1'b1);
        hi = int'(bus0.o_wb_cyc);
        for (int k = 0; k < 3; k++) begin
            tick();
            hi += int'(bus0.o_wb_cyc);
        end
        chk32("st_cyc_cycles", 32'(hi), 32'd4);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk1("st_cyc_drop", bus0.o_wb_cyc, 1'b0);
        chk1("st_ack",      bus0.o_ack, 1'b1);
        chk1("st_err",      bus0.o_err, 1'b0);
        chk1("race_ack",    bus4.o_ack, 1'b1);
        chk1("race_err",    bus4.o_err, 1'b0);
        tick();
        chk1("st_ack_pulse", bus0.o_ack, 1'b0);
        chk1("race_err_after", bus4.o_err, 1'b0);
        chk1("race_idle",   bus4.o_busy, 1'b0);

        exp_rdat = 32'h0;
        for (int i = 0; i < NTV; i++) begin
            req = 1'b1; we = tv[i].we; size = tv[i].size; adr = tv[i].adr; dat = tv[i].dat;
            tick();
            req = 1'b0;
            if (tv[i].err) begin
                chk1($sformatf("v%0d_mis_cyc", i),  bus0.o_wb_cyc, 1'b0);
                chk1($sformatf("v%0d_mis_busy", i), bus0.o_busy, 1'b1);
                tick();
                chk1($sformatf("v%0d_mis_err", i),  bus0.o_err, 1'b1);
                chk1($sformatf("v%0d_mis_cyc2", i), bus0.o_wb_cyc, 1'b0);
            end else begin
                chk1 ($sformatf("v%0d_cyc", i), bus0.o_wb_cyc, 1'b1);
                chk1 ($sformatf("v%0d_stb", i), bus0.o_wb_stb, 1'b1);
                chk1 ($sformatf("v%0d_we", i),  bus0.o_wb_we, tv[i].we);
                chk32($sformatf("v%0d_adr", i), {2'b0, bus0.o_wb_adr}, {2'b0, tv[i].adr[31:2]});
                chk32($sformatf("v%0d_sel", i), {28'b0, bus0.o_wb_sel}, {28'b0, tv[i].sel});
                if (tv[i].we)
                    chk32($sformatf("v%0d_wdat", i), bus0.o_wb_dat, tv[i].dat);
                wb_ack = 1'b1; wb_rdt = tv[i].rdt;
                tick();
                wb_ack = 1'b0; wb_rdt = 32'hFFFF_FFFF;
                chk1($sformatf("v%0d_cyc_drop", i), bus0.o_wb_cyc, 1'b0);
                if (tv[i].we) begin
                    chk1($sformatf("v%0d_ack", i),  bus0.o_ack, 1'b1);
                    chk1($sformatf("v%0d_load", i), bus0.o_load, 1'b0);
                end else begin
                    exp_rdat = tv[i].rdt;
                    chk1($sformatf("v%0d_ack_early", i), bus0.o_ack, 1'b0);
                    tick();
                    chk1($sformatf("v%0d_ack", i),  bus0.o_ack, 1'b1);
                    chk1($sformatf("v%0d_load", i), bus0.o_load, 1'b1);
                end
                chk32($sformatf("v%0d_rdat", i), bus0.o_rdat, exp_rdat);
            end
            tick();
            chk1($sformatf("v%0d_pulse_end", i), bus0.o_ack | bus0.o_load | bus0.o_err, 1'b0);
            chk1($sformatf("v%0d_idle", i), bus0.o_busy, 1'b0);
        end

        // Timeout: TIMEOUT=4 aborts, TIMEOUT=0 waits indefinitely.
        req = 1'b1; we = 1'b0; size = 2'b10; adr = 32'h0000_6000;
        tick();
        req = 1'b0;
        hi = int'(bus4.o_wb_cyc);
        err_at = -1;
        for (int j = 1; j < 8; j++) begin
            tick();
            hi += int'(bus4.o_wb_cyc);
            if (bus4.o_err && err_at < 0) err_at = j;
        end
        chk32("to_cyc_cycles", 32'(hi), 32'd4);
        chk32("to_err_cycle", 32'(err_at), 32'd5);
        chk1 ("to_idle", bus4.o_busy, 1'b0);

        bad_cyc = 0; bad_err = 0; bad_adr = 0;
        adr = 32'h0000_7000; we = 1'b1;
        for (int j = 0; j < 1000; j++) begin
            req = ~req;
            tick();
            if (!bus0.o_wb_cyc) bad_cyc++;
            if (bus0.o_err) bad_err++;
            if (bus0.o_wb_adr != 30'h0000_1800) bad_adr++;
        end
        req = 1'b0;
        chk32("noto_cyc_low", 32'(bad_cyc), 32'd0);
        chk32("noto_err",     32'(bad_err), 32'd0);
        chk32("noto_adr_chg", 32'(bad_adr), 32'd0);
        wb_ack = 1'b1; wb_rdt = 32'h0BAD_F00D;
        tick();
        wb_ack = 1'b0;
        chk1("noto_cyc_drop", bus0.o_wb_cyc, 1'b0);
        tick();
        chk1 ("noto_load", bus0.o_load, 1'b1);
        chk32("noto_rdat", bus0.o_rdat, 32'h0BAD_F00D);

        // Asynchronous reset in the middle of a bus cycle.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        req = 1'b1; we = 1'b1; size = 2'b10; adr = 32'h0000_8000; dat = 32'h1;
        tick();
        req = 1'b0;
        tick();
        chk1("ar_cyc_before", bus0.o_wb_cyc, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("ar_cyc_async", bus0.o_wb_cyc, 1'b0);
        chk1("ar_busy_async", bus0.o_busy, 1'b0);
        tick();
        rst_n = 1'b1;
        wb_ack = 1'b1;
        tick(); tick();
        wb_ack = 1'b0;
        chk1 ("ar_ack_ignored", bus0.o_ack, 1'b0);
        chk1 ("ar_cyc_after", bus0.o_wb_cyc, 1'b0);
        chk1 ("ar_idle", bus0.o_busy, 1'b0);
        chk32("ar_rdat", bus0.o_rdat, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
